scan_buffer_ctrl: RTL and testbench
===================================

// Module: scan_buffer_ctrl
// PURPOSE
//  Write-side sequencer for the sonar line buffer (dual-port BRAM, 2^ADDR_W x DATA_W).
//  Turns the raw echo-sample stream into one decimated scan line per start pulse and writes it into
//  a ping-pong bank; the completed bank is handed to the display reader via ready/ack.
//  Sits between the echo ADC/sampler and the buffer write port; the display side reads bank rd_bank.
// PARAMETERS
//  ADDR_W  10  buffer address width; MSB selects the bank, so one line = 2^(ADDR_W-1) = 512 entries
//  DATA_W  8   sample/buffer data width
//  DECIM   4   input samples per written entry (max-hold over the group), range 1..255
// PORTS
//  clk           in   1       single clock, all logic on the rising edge
//  reset         in   1       synchronous, active-high
//  start         in   1       pulse: begin capturing one line into the write bank
//  abort         in   1       pulse: cancel the current line; no bank swap
//  sample_valid  in   1       sample_data is valid this cycle
//  sample_data   in   DATA_W  echo amplitude, unsigned
//  busy          out  1       capture in progress (state CAPTURE)
//  wr_en         out  1       buffer write strobe, one cycle per entry
//  wr_addr       out  ADDR_W  {wbank, idx}
//  wr_data       out  DATA_W  max of the DECIM-sample group
//  rd_bank       out  1       bank holding the last completed line (= ~wbank)
//  frame_ready   out  1       completed line waiting in rd_bank
//  frame_ack     in   1       pulse from reader: done with rd_bank
//  overrun       out  1       sticky: a line completed while frame_ready was still high
//  frame_count   out  8       completed lines, wraps 255->0
// BEHAVIOUR
//  Reset: state IDLE, wbank=0 (rd_bank=1), idx=0, grp=0, max=0; all outputs 0 except rd_bank=1.
//  States: IDLE -start-> CAPTURE -last entry written-> DONE (1 cycle) -> IDLE; abort in CAPTURE -> IDLE.
//  IDLE: sample_valid ignored. start while CAPTURE/DONE ignored. abort while IDLE/DONE ignored.
//  CAPTURE, per sample_valid: grp==0 loads max<=sample, else max<=max(max,sample) (unsigned);
//   grp counts 0..DECIM-1. On the DECIM-th sample: next cycle wr_en=1, wr_data=max incl. that sample,
//   wr_addr={wbank,idx}; idx then increments; grp returns to 0. Latency: last group sample -> wr_en = 1 clk.
//  DECIM==1: every valid sample is written directly, 1-cycle latency, back-to-back valid supported.
//  Line end: write with idx==2^(ADDR_W-1)-1 -> DONE; idx wraps to 0; no write past bank end.
//  DONE cycle: frame_count+1; if frame_ready (after same-cycle ack) is 0: wbank<=~wbank, frame_ready<=1;
//   else overrun<=1, no swap, the unread line stays intact and the next line overwrites the write bank.
//  frame_ack clears frame_ready the next cycle; ack with frame_ready=0 is ignored.
//  Simultaneous ack and DONE: ack applied first -> swap, frame_ready stays 1, no overrun.
//  abort: next cycle IDLE, wr_en=0, pending partial group discarded, idx/grp<=0, wbank unchanged,
//   entries already written are left in place (line is invalid, never flagged ready).
//  overrun clears only on reset. Reset mid-capture: everything returns to reset values the next cycle.
//  wr_en is never high in IDLE; wr_addr/wr_data hold their last value when wr_en=0.
// STRUCTURE
//  Shared package scan_pkg: state enum {S_IDLE,S_CAPTURE,S_DONE}, LINE_ADDR_W, SAMPLE_W constants.
//  One sub-module: max_hold_decim (grp counter + running max, emits entry_valid/entry_data);
//  this top holds the FSM, idx/bank tracking and the ready/ack handshake.
// TESTING
//  1 DECIM=4, start, 2048 valid samples ramp 0..255 wrap -> 512 writes to addr 0..511, entry 0 = 3,
//    frame_ready=1, rd_bank=0, frame_count=1, busy low after DONE.
//  2 Group {5,200,7,9} with gaps in sample_valid -> single write wr_data=200, 1 clk after 4th sample.
//  3 Complete line, no ack, second line -> overrun=1, rd_bank stays 0, writes go to 512..1023 again.
//  4 frame_ack in the DONE cycle of line 2 -> rd_bank=1, frame_ready=1, overrun=0.
//  5 abort after 100 entries -> IDLE next cycle, no ready, next start writes from {wbank,0}.
//  6 reset asserted mid-capture and at DONE -> all outputs at reset values; start afterwards writes from 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and default widths for the sonar line-buffer write sequencer.
package scan_pkg;

    localparam int unsigned LINE_ADDR_W = 9;
    localparam int unsigned SAMPLE_W    = 8;
    localparam int unsigned GRP_W       = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/max_hold_decim.sv
// Groups DECIM accepted samples and emits the unsigned maximum of each group
// one clock after the group's last sample.
module max_hold_decim
    import scan_pkg::*;
#(
    parameter int unsigned DATA_W = SAMPLE_W,
    parameter int unsigned DECIM  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sampleValid,
    input  logic [DATA_W-1:0] sampleData,
    output logic              groupDone_c,
    output logic              entryValid,
    output logic [DATA_W-1:0] entryData
);

    logic [GRP_W-1:0]  grp;
    logic [DATA_W-1:0] runMax;
    logic [DATA_W-1:0] groupMax;
    logic              accept;

    // Group maximum including the sample on the input this cycle.
    always_comb begin
        accept      = enable && sampleValid;
        groupMax    = sampleData;
        if ((grp != '0) && (runMax > sampleData)) begin
            groupMax = runMax;
        end
        groupDone_c = accept && (grp == GRP_W'(DECIM - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grp        <= '0;
            runMax     <= '0;
            entryValid <= 1'b0;
            entryData  <= '0;
        end else begin
            entryValid <= groupDone_c;
            // Leaving capture discards any partial group.
            if (!enable) begin
                grp    <= '0;
                runMax <= '0;
            end else if (accept) begin
                runMax <= groupMax;
                if (groupDone_c) begin
                    grp       <= '0;
                    entryData <= groupMax;
                end else begin
                    grp <= grp + GRP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/scan_buffer_ctrl.sv
// Write-side sequencer: decimates the echo stream into one line per start pulse,
// writes it into a ping-pong bank and hands completed banks to the reader.
module scan_buffer_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned ADDR_W = LINE_ADDR_W + 1,
    parameter int unsigned DATA_W = SAMPLE_W,
    parameter int unsigned DECIM  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_bank,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              overrun,
    output logic [7:0]        frame_count
);

    localparam int unsigned     IDX_W    = ADDR_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t           state;
    state_t           stateNext;
    logic [IDX_W-1:0] idx;
    logic             wbank;
    logic             captureEn;
    logic             doneCycle;
    logic             lineEnd;
    logic             readyAfterAck;
    logic             groupDone;
    logic             entryValid;
    logic [DATA_W-1:0] entryData;

    max_hold_decim #(
        .DATA_W (DATA_W),
        .DECIM  (DECIM)
    ) uDecim (
        .clk         (clk),
        .reset       (reset),
        .enable      (captureEn),
        .sampleValid (sample_valid),
        .sampleData  (sample_data),
        .groupDone_c (groupDone),
        .entryValid  (entryValid),
        .entryData   (entryData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    stateNext = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    stateNext = S_IDLE;
                end else if (lineEnd) begin
                    stateNext = S_DONE;
                end
            end
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // An abort in the same cycle as a group end suppresses that write.
    always_comb begin
        captureEn     = (state == S_CAPTURE) && !abort;
        doneCycle     = (state == S_DONE);
        lineEnd       = groupDone && (idx == LAST_IDX);
        readyAfterAck = frame_ready && !frame_ack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            wbank       <= 1'b0;
            busy        <= 1'b0;
            wr_addr     <= '0;
            rd_bank     <= 1'b1;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            busy <= (stateNext == S_CAPTURE);

            if (!captureEn) begin
                idx <= '0;
            end else if (groupDone) begin
                wr_addr <= {wbank, idx};
                idx     <= idx + IDX_W'(1);
            end

            // A same-cycle ack frees the read bank before the swap decision.
            if (doneCycle) begin
                frame_count <= frame_count + 8'd1;
                if (readyAfterAck) begin
                    overrun <= 1'b1;
                end else begin
                    wbank       <= ~wbank;
                    rd_bank     <= wbank;
                    frame_ready <= 1'b1;
                end
            end else if (frame_ack) begin
                frame_ready <= 1'b0;
            end
        end
    end

    assign wr_en   = entryValid;
    assign wr_data = entryData;

endmodule

// File: tb/tb_scan_buffer_ctrl.sv
// Self-checking bench for scan_buffer_ctrl: queue-based line model compared every
// cycle, plus directed literal expectations for each scenario.
module tb_scan_buffer_ctrl;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DECIM  = 4;
    localparam int          LINE   = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_bank;
    logic              frame_ready;
    logic              frame_ack;
    logic              overrun;
    logic [7:0]        frame_count;

    int checks = 0;
    int passes = 0;

    // write log gathered from the DUT for the literal checks
    int          wrCount = 0;
    logic [31:0] firstAddr = 0;
    logic [31:0] firstData = 0;
    logic [31:0] lastAddr = 0;
    logic [31:0] lastData = 0;

    // reference model: phase 0 idle, 1 capturing, 2 line just finished
    int                mPhase = 0;
    int                mIdx = 0;
    logic              mWbank = 1'b0;
    logic              mReady = 1'b0;
    logic              mOverrun = 1'b0;
    logic [7:0]        mCount = 8'd0;
    logic [DATA_W-1:0] grpQ[$];
    logic              eWrEn = 1'b0;
    logic [ADDR_W-1:0] eWrAddr = '0;
    logic [DATA_W-1:0] eWrData = '0;

    scan_buffer_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DECIM  (DECIM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .busy         (busy),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_bank      (rd_bank),
        .frame_ready  (frame_ready),
        .frame_ack    (frame_ack),
        .overrun      (overrun),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    function automatic logic [DATA_W-1:0] groupMax();
        logic [DATA_W-1:0] m = grpQ[0];
        foreach (grpQ[i]) begin
            if (grpQ[i] > m) m = grpQ[i];
        end
        return m;
    endfunction

    // One clock of the line-level model, from the inputs seen at the rising edge.
    task automatic modelStep();
        if (reset) begin
            mPhase = 0; mIdx = 0; mWbank = 1'b0; mReady = 1'b0; mOverrun = 1'b0;
            mCount = 8'd0; grpQ.delete(); eWrEn = 1'b0; eWrAddr = '0; eWrData = '0;
        end else begin
            eWrEn = 1'b0;
            if (mPhase == 2) begin
                mCount = mCount + 8'd1;
                if (mReady && !frame_ack) begin
                    mOverrun = 1'b1;
                end else begin
                    mWbank = !mWbank;
                    mReady = 1'b1;
                end
                mPhase = 0;
            end else begin
                if (frame_ack) mReady = 1'b0;
                if (mPhase == 0) begin
                    if (start) mPhase = 1;
                end else if (abort) begin
                    mPhase = 0;
                    mIdx = 0;
                    grpQ.delete();
                end else if (sample_valid) begin
                    grpQ.push_back(sample_data);
                    if (grpQ.size() == DECIM) begin
                        eWrEn   = 1'b1;
                        eWrData = groupMax();
                        eWrAddr = ADDR_W'(int'(mWbank) * LINE + mIdx);
                        grpQ.delete();
                        mIdx++;
                        if (mIdx == LINE) begin
                            mIdx = 0;
                            mPhase = 2;
                        end
                    end
                end
            end
        end
    endtask

    // Per-cycle comparison shortly after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            #2;
            check("busy", busy, (mPhase == 1) ? 1 : 0);
            check("wr_en", wr_en, eWrEn);
            check("wr_addr", wr_addr, eWrAddr);
            check("wr_data", wr_data, eWrData);
            check("rd_bank", rd_bank, !mWbank);
            check("frame_ready", frame_ready, mReady);
            check("overrun", overrun, mOverrun);
            check("frame_count", frame_count, mCount);
            if (wr_en === 1'b1) begin
                if (wrCount == 0) begin
                    firstAddr = 32'(wr_addr);
                    firstData = 32'(wr_data);
                end
                wrCount++;
                lastAddr = 32'(wr_addr);
                lastData = 32'(wr_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLog();
        wrCount = 0; firstAddr = 0; firstData = 0; lastAddr = 0; lastData = 0;
    endtask

    task automatic pulseStart();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulseAbort();
        abort = 1'b1; @(negedge clk); abort = 1'b0;
    endtask

    task automatic sendOne(input logic [DATA_W-1:0] d);
        sample_valid = 1'b1; sample_data = d; @(negedge clk); sample_valid = 1'b0;
    endtask

    // n back-to-back samples, value i*mul+add truncated to DATA_W
    task automatic feed(input int n, input int mul, input int add);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = DATA_W'(i * mul + add);
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0;
        sample_data = '0; frame_ack = 1'b0;
        idle(2);
        check("rst_busy", busy, 0);
        check("rst_rd_bank", rd_bank, 1);
        check("rst_frame_count", frame_count, 0);
        reset = 1'b0;

        // samples while idle never reach the buffer
        feed(8, 3, 1); idle(2);
        check("idle_no_write", wrCount, 0);

        // full ramp line
        clearLog(); pulseStart(); feed(2048, 1, 0); idle(3);
        check("t1_writes", wrCount, 512);
        check("t1_first_addr", firstAddr, 0);
        check("t1_entry0", firstData, 3);
        check("t1_last_addr", lastAddr, 511);
        check("t1_last_data", lastData, 255);
        check("t1_ready", frame_ready, 1);
        check("t1_rd_bank", rd_bank, 0);
        check("t1_count", frame_count, 1);
        check("t1_busy", busy, 0);

        // gapped group, with a start pulse during capture that must be ignored
        clearLog(); pulseStart();
        sendOne(8'd5); idle(2);
        sendOne(8'd200); start = 1'b1; idle(1); start = 1'b0;
        sendOne(8'd7); idle(3);
        check("t2_no_early_write", wrCount, 0);
        sendOne(8'd9);
        check("t2_wr_en", wr_en, 1);
        check("t2_wr_data", wr_data, 200);
        check("t2_wr_addr", wr_addr, 512);

        // finish the line without an ack: overrun, no swap
        feed(2044, 37, 11); idle(3);
        check("t3_writes", wrCount, 512);
        check("t3_last_addr", lastAddr, 1023);
        check("t3_overrun", overrun, 1);
        check("t3_rd_bank", rd_bank, 0);
        check("t3_ready", frame_ready, 1);
        check("t3_count", frame_count, 2);

        // abort after 100 entries plus a partial group
        clearLog(); pulseStart(); feed(402, 13, 5); pulseAbort();
        check("t5_busy", busy, 0);
        check("t5_writes", wrCount, 100);
        check("t5_first_addr", firstAddr, 512);
        idle(2);
        check("t5_no_late_write", wrCount, 100);
        check("t5_ready", frame_ready, 1);
        check("t5_count", frame_count, 2);
        pulseAbort(); idle(1);
        clearLog(); pulseStart(); feed(4, 50, 1); idle(2);
        check("t5_restart_addr", firstAddr, 512);
        check("t5_restart_data", firstData, 151);
        pulseAbort(); idle(2);

        // ack in the DONE cycle of the second line
        reset = 1'b1; idle(1); reset = 1'b0;
        pulseStart(); feed(2048, 7, 3); idle(2);
        pulseStart(); feed(2048, 11, 0);
        frame_ack = 1'b1; @(negedge clk); frame_ack = 1'b0;
        idle(2);
        check("t4_rd_bank", rd_bank, 1);
        check("t4_ready", frame_ready, 1);
        check("t4_overrun", overrun, 0);
        check("t4_count", frame_count, 2);
        frame_ack = 1'b1; @(negedge clk); frame_ack = 1'b0;
        check("t4_ack_clears", frame_ready, 0);
        frame_ack = 1'b1; @(negedge clk); frame_ack = 1'b0;
        idle(1);

        // reset mid-capture
        pulseStart(); feed(200, 3, 9);
        reset = 1'b1; @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_wr_en", wr_en, 0);
        check("t6_wr_addr", wr_addr, 0);
        check("t6_wr_data", wr_data, 0);
        check("t6_rd_bank", rd_bank, 1);
        check("t6_count", frame_count, 0);
        reset = 1'b0;
        clearLog(); pulseStart(); feed(4, 9, 9); idle(2);
        check("t6_restart_addr", firstAddr, 0);

        // reset in the DONE cycle: no count, no ready
        feed(2044, 5, 2);
        reset = 1'b1; @(negedge clk);
        check("t6_done_count", frame_count, 0);
        check("t6_done_ready", frame_ready, 0);
        check("t6_done_rd_bank", rd_bank, 1);
        reset = 1'b0;
        clearLog(); pulseStart(); feed(4, 9, 9); idle(2);
        check("t6_done_restart_addr", firstAddr, 0);
        pulseAbort(); idle(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
